aemb_dwb_timer: RTL and testbench
=================================

AEMB_DWB_TIMER -- requirements
Module: aemb_dwb_timer

Interface
REQ-001 Parameter: AEMB_DWB, default 18; data-bus address width, with the port carrying bits [AEMB_DWB-1:2].
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port sys_clk_i, input, 1 bit; the single clock, all state changes on its rising edge.
REQ-004 Port sys_rst_ni, input, 1 bit; active-low asynchronous reset.
REQ-005 Port dwb_cyc_i, input, 1 bit; Wishbone cycle, already gated by the upstream address decoder.
REQ-006 Port dwb_stb_i, input, 1 bit; Wishbone strobe.
REQ-007 Port dwb_wre_i, input, 1 bit; write enable (1 = write).
REQ-008 Port dwb_adr_i, input, [AEMB_DWB-1:2]; word address, of which only bits [3:2] are decoded.
REQ-009 Port dwb_sel_i, input, 4 bits; byte lanes, bit 3 = data bits [31:24].
REQ-010 Port dwb_dat_i, input, 32 bits; write data.
REQ-011 Port dwb_dat_o, output, 32 bits; registered read data.
REQ-012 Port dwb_ack_o, output, 1 bit; transfer acknowledge.
REQ-013 Port sys_int_o, output, 1 bit; level interrupt to the core.

Function
REQ-014 Register map by adr[3:2]:
- 0 = CNT, count, R/W.
- 1 = CMP, compare, R/W.
- 2 = CTL, R/W: bit0 EN, bit1 IE, bit2 AUTO, bits[31:16] PRE, other bits read 0.
- 3 = STA, bit0 PEND, write-1-to-clear, other bits read 0.
REQ-015 Ack shall follow dwb_ack_o(next) = dwb_cyc_i & dwb_stb_i & !dwb_ack_o, giving one wait state and a single-cycle ack pulse.
REQ-016 A write shall take effect on the same edge that asserts dwb_ack_o, once per transfer.
REQ-017 Write byte lanes:
- Only lanes with sel=1 are updated.
- sel=0 writes still ack and change nothing.
REQ-018 Read data shall be loaded into dwb_dat_o on the edge that asserts dwb_ack_o, and shall hold otherwise.
REQ-019 Read data shall reflect register contents before any same-edge update.
REQ-020 Prescaler:
- A 16-bit prescaler counts while EN=1.
- It emits a tick and reloads to 0 when it equals PRE, so CNT advances every PRE+1 clocks.
- PRE=0 gives a tick every clock.
- The prescaler is cleared when EN=0.
REQ-021 On a tick, CNT shall increment by 1, wrapping modulo 2^32 from 0xFFFFFFFF to 0.
REQ-022 Match: when a tick occurs with CNT==CMP, PEND shall set.
- AUTO=1: CNT loads 0 instead of incrementing.
- AUTO=0: CNT increments normally.
REQ-023 A bus write to CNT on the same edge as a tick shall win: CNT takes the written bytes and the increment is lost.
REQ-024 The match check shall still use the pre-write CNT.
REQ-025 A W1C to PEND on the same edge as a new match shall leave PEND=1 (set wins).
REQ-026 Writing CTL with EN 1->0 shall freeze CNT at its current value.
REQ-027 sys_int_o shall equal PEND & IE, registered, i.e. one cycle after PEND or IE changes.
REQ-028 Clearing IE shall mask sys_int_o but shall not clear PEND.
REQ-029 If dwb_stb_i drops while the ack cycle is pending, the transfer shall be abandoned: no ack and no write on the next edge.

Reset
REQ-030 On sys_rst_ni=0, asynchronously:
- CNT=0, CMP=0xFFFFFFFF, CTL=0, PEND=0, prescaler=0.
- dwb_ack_o=0, dwb_dat_o=0, sys_int_o=0.
REQ-031 Reset asserted mid-transfer shall drop the ack; the master must reissue the transfer.
REQ-032 The first edge after reset release shall act on current inputs.

Structure
REQ-033 Shared package aemb_dwb_pkg shall hold:
- register offsets (CNT/CMP/CTL/STA);
- CTL bit positions (EN, IE, AUTO) and PRE field bounds;
- reset constants (CMP reset value).
REQ-034 One sub-module, aemb_dwb_presc, shall hold the 16-bit prescaler.
- Inputs: ena, pre[15:0].
- Output: tick.
REQ-035 Bus decode, the register file and match logic shall live in the top module.

Verification
REQ-036 Read CNT after reset -> ack exactly 2 cycles after stb rises, dat_o=0x00000000; a 2nd read with stb held -> ack pulses every other cycle.
REQ-037 CMP=5, CTL=0x7 (EN, IE, AUTO, PRE=0) -> PEND set on the CNT==5 tick, CNT reloads 0, sys_int_o=1 one cycle later; W1C STA=1 -> sys_int_o=0 next cycle.
REQ-038 CTL=0x00030001 (PRE=3, EN) -> CNT advances every 4 clocks; CNT=0xFFFFFFFF, CMP=0 -> wraps to 0, then PEND sets at the next tick.
REQ-039 Write CNT=0x12345678 with sel=0x3 over CNT=0xAAAAAAAA -> CNT=0xAAAA5678; write with sel=0 -> ack, CNT unchanged.
REQ-040 W1C on STA on the same edge as a match -> PEND stays 1; write CNT=0x100 on the same edge as a tick -> CNT=0x100.
REQ-041 Assert sys_rst_ni=0 while dwb_ack_o=1 and PEND=1 -> all outputs 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/aemb_dwb_pkg.sv
// Shared definitions for the AEMB data-bus timer: register map, CTL/STA field
// positions, reset constants and a byte-lane merge helper.
package aemb_dwb_pkg;

    // Word offsets decoded from dwb_adr_i[3:2]
    typedef enum logic [1:0] {
        RegCnt = 2'd0,
        RegCmp = 2'd1,
        RegCtl = 2'd2,
        RegSta = 2'd3
    } reg_e;

    // CTL field positions
    localparam int unsigned CtlEn    = 0;
    localparam int unsigned CtlIe    = 1;
    localparam int unsigned CtlAuto  = 2;
    localparam int unsigned CtlPreLo = 16;
    localparam int unsigned CtlPreHi = 31;

    // STA field positions
    localparam int unsigned StaPend = 0;

    // Prescaler width, equal to the PRE field width
    localparam int unsigned PreW = CtlPreHi - CtlPreLo + 1;

    // Reset values
    localparam logic [31:0] CmpRst = 32'hFFFF_FFFF;

    // Replace only the byte lanes whose select bit is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aemb_dwb_presc.sv
// 16-bit prescaler: counts while enabled, ticks and reloads to zero when the
// count equals the programmed limit, giving one tick every pre+1 clocks.
module aemb_dwb_presc
    import aemb_dwb_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ena,
    input  logic [PreW-1:0] i_pre,
    output logic            o_tick
);

    logic [PreW-1:0] r_cnt;
    logic            w_hit;

    // Terminal-count detect and tick output
    always_comb begin
        w_hit  = (r_cnt == i_pre);
        o_tick = i_ena & w_hit;
    end

    // Counter held at zero while disabled so a re-enable starts a full period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_ena || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aemb_dwb_timer.sv
// Wishbone-attached 32-bit timer with compare match, optional auto-reload,
// prescaler and a level interrupt. One wait state per transfer.
module aemb_dwb_timer
    import aemb_dwb_pkg::*;
#(
    parameter int unsigned AEMB_DWB = 18
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_ni,
    input  logic                dwb_cyc_i,
    input  logic                dwb_stb_i,
    input  logic                dwb_wre_i,
    input  logic [AEMB_DWB-1:2] dwb_adr_i,
    input  logic [3:0]          dwb_sel_i,
    input  logic [31:0]         dwb_dat_i,
    output logic [31:0]         dwb_dat_o,
    output logic                dwb_ack_o,
    output logic                sys_int_o
);

    // Architectural state
    logic [31:0]     r_cnt;
    logic [31:0]     r_cmp;
    logic            r_en;
    logic            r_ie;
    logic            r_auto;
    logic [PreW-1:0] r_pre;
    logic            r_pend;

    // Bus-side registered outputs
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_int;

    // Decode and datapath
    reg_e            w_reg;
    logic            w_xfer;
    logic            w_wr_cnt;
    logic            w_wr_cmp;
    logic            w_wr_ctl;
    logic            w_wr_sta;
    logic            w_w1c;
    logic            w_tick;
    logic            w_match;
    logic [31:0]     w_ctl_rd;
    logic [31:0]     w_ctl_new;
    logic [31:0]     w_rdata;
    logic            w_unused_adr;

    aemb_dwb_presc u_presc (
        .i_clk   (sys_clk_i),
        .i_rst_n (sys_rst_ni),
        .i_ena   (r_en),
        .i_pre   (r_pre),
        .o_tick  (w_tick)
    );

    // Bus decode, read mux and match detect
    always_comb begin
        w_unused_adr = ^dwb_adr_i[AEMB_DWB-1:4];
        w_reg        = reg_e'(dwb_adr_i[3:2]);
        // A transfer is accepted only in the cycle before ack rises
        w_xfer       = dwb_cyc_i & dwb_stb_i & ~r_ack;
        w_wr_cnt     = w_xfer & dwb_wre_i & (w_reg == RegCnt);
        w_wr_cmp     = w_xfer & dwb_wre_i & (w_reg == RegCmp);
        w_wr_ctl     = w_xfer & dwb_wre_i & (w_reg == RegCtl);
        w_wr_sta     = w_xfer & dwb_wre_i & (w_reg == RegSta);
        w_w1c        = w_wr_sta & dwb_sel_i[0] & dwb_dat_i[StaPend];

        w_ctl_rd     = '0;
        w_ctl_rd[CtlEn]             = r_en;
        w_ctl_rd[CtlIe]             = r_ie;
        w_ctl_rd[CtlAuto]           = r_auto;
        w_ctl_rd[CtlPreHi:CtlPreLo] = r_pre;
        w_ctl_new    = byte_merge(w_ctl_rd, dwb_dat_i, dwb_sel_i);

        // Match uses the pre-write count even if CNT is being written
        w_match      = w_tick & (r_cnt == r_cmp);

        w_rdata      = '0;
        unique case (w_reg)
            RegCnt: w_rdata = r_cnt;
            RegCmp: w_rdata = r_cmp;
            RegCtl: w_rdata = w_ctl_rd;
            RegSta: w_rdata[StaPend] = r_pend;
        endcase
    end

    // Ack pulse and read-data capture
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_xfer;
            if (w_xfer) begin
                r_dat <= w_rdata;
            end
        end
    end

    // Register file: bus writes take priority over the count update
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_cnt  <= '0;
            r_cmp  <= CmpRst;
            r_en   <= 1'b0;
            r_ie   <= 1'b0;
            r_auto <= 1'b0;
            r_pre  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_wr_cnt) begin
                r_cnt <= byte_merge(r_cnt, dwb_dat_i, dwb_sel_i);
            end else if (w_tick) begin
                r_cnt <= (w_match && r_auto) ? 32'd0 : r_cnt + 32'd1;
            end
            if (w_wr_cmp) begin
                r_cmp <= byte_merge(r_cmp, dwb_dat_i, dwb_sel_i);
            end
            if (w_wr_ctl) begin
                r_en   <= w_ctl_new[CtlEn];
                r_ie   <= w_ctl_new[CtlIe];
                r_auto <= w_ctl_new[CtlAuto];
                r_pre  <= w_ctl_new[CtlPreHi:CtlPreLo];
            end
            // A new match beats a same-cycle clear
            r_pend <= (r_pend & ~w_w1c) | w_match;
        end
    end

    // Interrupt lags PEND/IE by one clock
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_int <= 1'b0;
        end else begin
            r_int <= r_pend & r_ie;
        end
    end

    // Output drive
    always_comb begin
        dwb_ack_o = r_ack;
        dwb_dat_o = r_dat;
        sys_int_o = r_int;
    end

endmodule

// File: tb/tb_aemb_dwb_timer.sv
// Directed self-checking bench for aemb_dwb_timer.
module tb_aemb_dwb_timer;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc;
    logic          stb;
    logic          wre;
    logic [AW-1:2] adr;
    logic [3:0]    sel;
    logic [31:0]   wdat;
    logic [31:0]   dat_o;
    logic          ack;
    logic          irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_tbl [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};

    always #5 clk = ~clk;

    aemb_dwb_timer #(.AEMB_DWB(AW)) dut (
        .sys_clk_i  (clk),
        .sys_rst_ni (rst_n),
        .dwb_cyc_i  (cyc),
        .dwb_stb_i  (stb),
        .dwb_wre_i  (wre),
        .dwb_adr_i  (adr),
        .dwb_sel_i  (sel),
        .dwb_dat_i  (wdat),
        .dwb_dat_o  (dat_o),
        .dwb_ack_o  (ack),
        .sys_int_o  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer: ack edge, then an idle edge so the next one can start
    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag, output logic [31:0] q);
        cyc = 1'b1; stb = 1'b1; wre = w; adr = '0; adr[3:2] = a; wdat = d; sel = s;
        @(posedge clk); #1;
        check({tag, "_ack"}, {31'b0, ack}, 32'd1);
        q = dat_o;
        cyc = 1'b0; stb = 1'b0; wre = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        logic [31:0] unused_q;
        xfer(1'b1, a, d, s, tag, unused_q);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] q;
        xfer(1'b0, a, 32'd0, 4'hF, tag, q);
        check(tag, q, exp);
    endtask

    initial begin
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; wre = 1'b0;
        adr = '0; sel = '0; wdat = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Ack in the second bus cycle; held strobe gives alternating acks
        cyc = 1'b1; stb = 1'b1; wre = 1'b0; adr = '0; sel = 4'hF;
        #4 check("r1_wait", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        check("r1_ack", {31'b0, ack}, 32'd1);
        check("r1_dat", dat_o, 32'd0);
        adr[3:2] = 2'd1;
        @(posedge clk); #1 check("r2_gap", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        check("r2_ack", {31'b0, ack}, 32'd1);
        check("r2_dat", dat_o, 32'hFFFF_FFFF);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 check("r2_drop", {31'b0, ack}, 32'd0);
        rd(2'd2, 32'd0, "ctl_rst");

        // Byte lanes, sel=0, abandoned transfer, CTL reserved bits
        wr(2'd0, 32'hAAAA_AAAA, 4'hF, "cnt_a");
        wr(2'd0, 32'h1234_5678, 4'h3, "cnt_lo");
        rd(2'd0, 32'hAAAA_5678, "cnt_lanes");
        wr(2'd0, 32'hFFFF_FFFF, 4'h0, "cnt_sel0");
        rd(2'd0, 32'hAAAA_5678, "cnt_sel0_rd");
        cyc = 1'b1; stb = 1'b1; wre = 1'b1; adr = '0; wdat = 32'h55; sel = 4'hF;
        #3 cyc = 1'b0; stb = 1'b0; wre = 1'b0;
        @(posedge clk); #1 check("abandon_ack", {31'b0, ack}, 32'd0);
        rd(2'd0, 32'hAAAA_5678, "abandon_cnt");
        wr(2'd2, 32'hFFFF_FFF8, 4'hF, "ctl_pre");
        rd(2'd2, 32'hFFFF_0000, "ctl_rd");

        // Auto-reload match with interrupt, PRE=0; E = ack edge of CTL=7
        wr(2'd0, 32'd0, 4'hF, "cnt0");
        wr(2'd1, 32'd5, 4'hF, "cmp5");
        wr(2'd2, 32'h7, 4'hF, "ctl7");
        repeat (5) @(posedge clk);
        #1 check("irq_at_match", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 check("irq_after", {31'b0, irq}, 32'd1);
        wr(2'd3, 32'd1, 4'hF, "w1c_a");
        check("irq_cleared", {31'b0, irq}, 32'd0);
        rd(2'd3, 32'd0, "sta_clear");
        // Disable lands on the CNT==5 tick: match still fires and reloads 0
        wr(2'd2, 32'h6, 4'hF, "ctl6");
        check("irq_rematch", {31'b0, irq}, 32'd1);
        rd(2'd0, 32'd0, "cnt_auto_frozen");
        wr(2'd2, 32'h0, 4'hF, "ctl_ie_off");
        check("irq_masked", {31'b0, irq}, 32'd0);
        rd(2'd3, 32'd1, "pend_kept");
        wr(2'd3, 32'd1, 4'hF, "w1c_b");
        rd(2'd3, 32'd0, "sta_clear_b");

        // PRE=3: count advances every 4 clocks
        wr(2'd0, 32'd0, 4'hF, "cnt0_b");
        wr(2'd1, 32'hFFFF_FFFF, 4'hF, "cmp_max");
        wr(2'd2, 32'h0003_0001, 4'hF, "ctl_pre3");
        for (int i = 0; i < 5; i++) begin
            rd(2'd0, exp_tbl[i], $sformatf("pre3_%0d", i));
        end
        wr(2'd2, 32'h0, 4'hF, "ctl_stop");
        repeat (8) @(posedge clk);
        #1 rd(2'd0, 32'd3, "cnt_frozen");

        // Wrap and match at zero, no auto-reload
        wr(2'd0, 32'hFFFF_FFFF, 4'hF, "cnt_max");
        wr(2'd1, 32'd0, 4'hF, "cmp0");
        wr(2'd2, 32'h1, 4'hF, "ctl_en");
        rd(2'd3, 32'd0, "wrap_nopend");
        rd(2'd0, 32'd2, "wrap_cnt");
        rd(2'd3, 32'd1, "wrap_pend");
        wr(2'd2, 32'h0, 4'hF, "ctl_stop_b");
        wr(2'd3, 32'd1, 4'hF, "w1c_c");
        rd(2'd3, 32'd0, "sta_clear_c");

        // W1C colliding with a match; CNT write colliding with a tick
        wr(2'd0, 32'd0, 4'hF, "cnt0_c");
        wr(2'd1, 32'd2, 4'hF, "cmp2");
        wr(2'd2, 32'h1, 4'hF, "ctl_en_b");
        @(posedge clk); #1;
        wr(2'd3, 32'd1, 4'hF, "w1c_collide");
        rd(2'd3, 32'd1, "set_wins");
        wr(2'd0, 32'h100, 4'hF, "cnt_tick_wr");
        // Written 0x100, then one more tick before the read's ack edge
        rd(2'd0, 32'h101, "write_wins");

        // Asynchronous reset with ack, read data and interrupt high
        wr(2'd2, 32'h2, 4'hF, "ctl_ie");
        check("irq_pre_rst", {31'b0, irq}, 32'd1);
        cyc = 1'b1; stb = 1'b1; wre = 1'b0; adr = '0; adr[3:2] = 2'd3; sel = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'b0, ack}, 32'd1);
        check("pre_rst_dat", dat_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ack", {31'b0, ack}, 32'd0);
        check("async_dat", dat_o, 32'd0);
        check("async_irq", {31'b0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        rd(2'd1, 32'hFFFF_FFFF, "post_cmp");
        rd(2'd3, 32'd0, "post_sta");
        rd(2'd2, 32'd0, "post_ctl");
        rd(2'd0, 32'd0, "post_cnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
